// File: rtl/sdram_wb_arbiter.sv
// sdram_wb_arbiter: two Wishbone masters share one SDRAM controller slave.
// Round-robin between simultaneous requests and a locked grant for the whole
// cyc. A watchdog aborts a strobe that waits too long for ack.
module sdram_wb_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk,
  input  logic            wb_rst_n,

  // master 0 (instruction/data bus)
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,

  // master 1 (DMA/peripheral)
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,

  // SDRAM controller slave port
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,

  output logic [1:0]      grant_o
);

  localparam int SW = DW / 8;

  // The counter value seen during the last permitted waiting cycle; the
  // abort fires in the cycle where the wait count would reach TIMEOUT.
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT - 1);

  // Encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t        state, state_nxt;
  logic          rr, rr_nxt;           // index of the master served last
  logic [15:0]   wd_cnt, wd_cnt_nxt;
  logic          timeout;

  // Signals of whichever master the FSM currently selects.
  logic          own_cyc, own_stb, own_we;
  logic [AW-1:0] own_adr;
  logic [DW-1:0] own_dat;
  logic [SW-1:0] own_sel;
  logic          own_ack, own_err;

  // Select the current owner's request lines (m0 whenever not OWN1).
  always_comb begin
    if (state == OWN1) begin
      own_cyc = m1_cyc_i;
      own_stb = m1_stb_i;
      own_we  = m1_we_i;
      own_adr = m1_adr_i;
      own_dat = m1_dat_i;
      own_sel = m1_sel_i;
    end else begin
      own_cyc = m0_cyc_i;
      own_stb = m0_stb_i;
      own_we  = m0_we_i;
      own_adr = m0_adr_i;
      own_dat = m0_dat_i;
      own_sel = m0_sel_i;
    end
  end

  // Next-state, watchdog and slave-port outputs.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path through
    // the case statement can leave a signal unassigned and infer a latch.
    state_nxt  = state;
    rr_nxt     = rr;
    wd_cnt_nxt = '0;
    timeout    = 1'b0;
    own_ack    = 1'b0;
    own_err    = 1'b0;
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_dat_o    = '0;
    s_sel_o    = '0;

    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = rr ? OWN0 : OWN1;
        end else if (m0_cyc_i) begin
          state_nxt = OWN0;
        end else if (m1_cyc_i) begin
          state_nxt = OWN1;
        end
      end

      OWN0, OWN1: begin
        s_cyc_o = own_cyc;
        s_stb_o = own_stb;
        s_we_o  = own_we;
        s_adr_o = own_adr;
        s_dat_o = own_dat;
        s_sel_o = own_sel;

        // Count only strobe cycles still waiting; a same-cycle ack beats the abort.
        if (own_stb && !s_ack_i && !s_err_i) begin
          if (wd_cnt == WD_LIMIT) begin
            timeout = 1'b1;
          end else begin
            wd_cnt_nxt = wd_cnt + 16'd1;
          end
        end

        if (timeout) begin
          s_cyc_o = 1'b0;
          s_stb_o = 1'b0;
          own_err = 1'b1;
        end else begin
          own_ack = s_ack_i;
          own_err = s_err_i;
        end

        // Release on cyc drop or abort; remember who was just served.
        if (timeout || !own_cyc) begin
          state_nxt = IDLE;
          rr_nxt    = (state == OWN1);
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin bit and watchdog registers.
  always_ff @(posedge wb_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!wb_rst_n) begin
      state  <= IDLE;
      rr     <= 1'b1;
      wd_cnt <= '0;
    end else begin
      state  <= state_nxt;
      rr     <= rr_nxt;
      wd_cnt <= wd_cnt_nxt;
    end
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = (state == OWN0) && own_ack;
  assign m0_err_o = (state == OWN0) && own_err;
  assign m1_ack_o = (state == OWN1) && own_ack;
  assign m1_err_o = (state == OWN1) && own_err;
  assign grant_o  = state;

endmodule

// File: tb/tb_sdram_wb_arbiter.sv
// Directed self-checking bench for sdram_wb_arbiter (built with TIMEOUT=4).
module tb_sdram_wb_arbiter;

  logic        wb_clk, wb_rst_n;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_ack_o, m0_err_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_ack_i, s_err_i;
  logic [1:0]  grant_o;

  int n_tests = 0;
  int n_fail  = 0;

  sdram_wb_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .wb_clk   (wb_clk),   .wb_rst_n (wb_rst_n),
    .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
    .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i), .m0_sel_i (m0_sel_i),
    .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
    .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
    .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i), .m1_sel_i (m1_sel_i),
    .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
    .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
    .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),  .s_sel_o  (s_sel_o),
    .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i),  .s_err_i  (s_err_i),
    .grant_o  (grant_o)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic m0_drive(input logic c, input logic s, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    m0_cyc_i = c; m0_stb_i = s; m0_we_i = w;
    m0_adr_i = a; m0_dat_i = d; m0_sel_i = sl;
  endtask

  task automatic m1_drive(input logic c, input logic s, input logic w,
                          input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
    m1_cyc_i = c; m1_stb_i = s; m1_we_i = w;
    m1_adr_i = a; m1_dat_i = d; m1_sel_i = sl;
  endtask

  task automatic do_reset();
    wb_rst_n = 1'b0;
    tick();
    wb_rst_n = 1'b1;
  endtask

  initial begin
    wb_rst_n = 1'b0;
    m0_drive(0, 0, 0, 0, 0, 0);
    m1_drive(0, 0, 0, 0, 0, 0);
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;

    // Reset state
    tick(); tick(); #1;
    check("rst_grant", grant_o, 32'h0);
    check("rst_s_cyc", {s_cyc_o, s_stb_o}, 32'h0);
    check("rst_acks", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}, 32'h0);
    wb_rst_n = 1'b1;

    // m0 single read, ack 3 cycles after first strobe cycle
    tick();
    m0_drive(1, 1, 0, 32'h0000_0100, 0, 4'hf);
    #1;
    check("a_pre_grant", grant_o, 32'h0);
    check("a_pre_cyc", s_cyc_o, 32'h0);
    tick(); #1;
    check("a_grant", grant_o, 32'h1);
    check("a_cyc_stb", {s_cyc_o, s_stb_o, s_we_o}, 32'h6);
    check("a_adr", s_adr_o, 32'h0000_0100);
    check("a_sel", s_sel_o, 32'hf);
    tick(); tick(); #1;
    check("a_wait_ack", {m0_ack_o, m0_err_o}, 32'h0);
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    #1;
    check("a_ack", m0_ack_o, 32'h1);
    check("a_data", m0_dat_o, 32'hDEAD_BEEF);
    check("a_m1_ack", m1_ack_o, 32'h0);
    check("a_ack_beats_wd", {m0_err_o, s_cyc_o}, 32'h1);
    tick();
    s_ack_i = 1'b0;
    m0_drive(0, 0, 0, 0, 0, 0);
    #1;
    check("a_ack_one_cycle", m0_ack_o, 32'h0);
    check("a_hold_grant", grant_o, 32'h1);
    tick(); #1;
    check("a_idle", grant_o, 32'h0);

    // Simultaneous requests after reset: m0 first, then m1, then m0 again
    do_reset();
    m0_drive(1, 1, 0, 32'h1000, 0, 4'hf);
    m1_drive(1, 1, 0, 32'h2000, 0, 4'h3);
    tick(); #1;
    check("b_first_m0", grant_o, 32'h1);
    check("b_adr_m0", s_adr_o, 32'h1000);
    s_ack_i = 1'b1; #1;
    check("b_ack_route0", {m0_ack_o, m1_ack_o}, 32'h2);
    tick();
    s_ack_i = 1'b0;
    m0_drive(0, 0, 0, 0, 0, 0);
    #1;
    check("b_m0_release", grant_o, 32'h1);
    tick(); #1;
    check("b_gap_grant", grant_o, 32'h0);
    check("b_gap_cyc", s_cyc_o, 32'h0);
    tick(); #1;
    check("b_then_m1", grant_o, 32'h2);
    check("b_adr_m1", s_adr_o, 32'h2000);
    check("b_sel_m1", s_sel_o, 32'h3);
    s_ack_i = 1'b1; #1;
    check("b_ack_route1", {m0_ack_o, m1_ack_o}, 32'h1);
    tick();
    s_ack_i = 1'b0;
    m1_drive(0, 0, 0, 0, 0, 0);
    m0_drive(1, 1, 0, 32'h1004, 0, 4'hf);
    tick();
    m1_drive(1, 1, 0, 32'h2004, 0, 4'h3);
    #1;
    check("b_gap2_grant", grant_o, 32'h0);
    tick(); #1;
    check("b_alt_m0", grant_o, 32'h1);
    check("b_alt_adr", s_adr_o, 32'h1004);
    m0_drive(0, 0, 0, 0, 0, 0);
    m1_drive(0, 0, 0, 0, 0, 0);
    tick(); tick(); #1;
    check("b_end_idle", grant_o, 32'h0);

    // m1 8-beat burst; m0 requests on beat 2 and must wait
    m1_drive(1, 1, 1, 32'h3000, 32'h1111_1111, 4'hf);
    tick(); #1;
    check("c_grant_m1", grant_o, 32'h2);
    for (int b = 0; b < 8; b++) begin
      s_ack_i = 1'b1;
      s_dat_i = 32'hA0 + 32'(b);
      if (b == 1) m0_drive(1, 1, 0, 32'h4000, 0, 4'hf);
      #1;
      check($sformatf("c_beat%0d_acks", b), {m1_ack_o, m0_ack_o}, 32'h2);
      check($sformatf("c_beat%0d_grant", b), grant_o, 32'h2);
      check($sformatf("c_beat%0d_bcast", b), m0_dat_o, 32'hA0 + 32'(b));
      tick();
    end
    s_ack_i = 1'b0;
    m1_drive(0, 0, 0, 0, 0, 0);
    #1;
    check("c_drop_grant", grant_o, 32'h2);
    check("c_drop_ack", m1_ack_o, 32'h0);
    tick(); #1;
    check("c_gap", grant_o, 32'h0);
    tick(); #1;
    check("c_m0_after2", grant_o, 32'h1);
    check("c_m0_adr", s_adr_o, 32'h4000);
    s_ack_i = 1'b1; #1;
    check("c_m0_ack", m0_ack_o, 32'h1);
    tick();
    s_ack_i = 1'b0;
    m0_drive(0, 0, 0, 0, 0, 0);
    tick(); #1;
    check("c_end_idle", grant_o, 32'h0);

    // Watchdog: slave never acks m0 (TIMEOUT=4)
    m0_drive(1, 1, 0, 32'h5000, 0, 4'hf);
    tick(); #1;
    check("d_w1", {grant_o, m0_err_o, s_cyc_o}, 32'h5);
    tick(); tick(); #1;
    check("d_w3", {m0_err_o, s_stb_o}, 32'h1);
    tick(); #1;
    check("d_w4_err", m0_err_o, 32'h1);
    check("d_w4_cyc", {s_cyc_o, s_stb_o}, 32'h0);
    check("d_w4_m1err", m1_err_o, 32'h0);
    check("d_w4_grant", grant_o, 32'h1);
    tick(); #1;
    check("d_after_grant", grant_o, 32'h0);
    check("d_after_err", m0_err_o, 32'h0);
    tick(); #1;
    check("d_rearb", grant_o, 32'h1);
    check("d_rearb_cyc", {s_cyc_o, m0_err_o}, 32'h2);
    s_err_i = 1'b1; #1;
    check("d_slave_err", {m0_err_o, m0_ack_o, m1_err_o}, 32'h4);
    tick();
    s_err_i = 1'b0;
    m0_drive(0, 0, 0, 0, 0, 0);
    tick(); #1;
    check("d_end_idle", grant_o, 32'h0);

    // Reset during an m1 write wait state
    m1_drive(1, 1, 1, 32'h6000, 32'hCAFE_F00D, 4'hc);
    tick(); #1;
    check("e_grant", grant_o, 32'h2);
    check("e_we_dat", s_dat_o, 32'hCAFE_F00D);
    check("e_sel_we", {s_sel_o, s_we_o}, 32'h19);
    tick();
    wb_rst_n = 1'b0;
    #1;
    check("e_wait", {m1_ack_o, m1_err_o}, 32'h0);
    tick(); #1;
    check("e_rst_cyc", s_cyc_o, 32'h0);
    check("e_rst_grant", grant_o, 32'h0);
    check("e_rst_m1", {m1_ack_o, m1_err_o}, 32'h0);
    tick();
    s_ack_i = 1'b1;
    #1;
    check("e_late_ack", {m0_ack_o, m1_ack_o}, 32'h0);
    tick();
    s_ack_i = 1'b0;
    m1_drive(0, 0, 0, 0, 0, 0);
    wb_rst_n = 1'b1;
    tick();
    m0_drive(1, 1, 0, 32'h7000, 0, 4'hf);
    m1_drive(1, 1, 0, 32'h8000, 0, 4'hf);
    tick(); #1;
    check("e_rr_reset", grant_o, 32'h1);
    m0_drive(0, 0, 0, 0, 0, 0);
    m1_drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
